// File: rtl/daq_link_pkg.sv
// Shared constants, state encoding and word builders for the DAQ link framing.
// The CSUM state exists only when DAQ_LINK_FRAMER_CHECKSUM_EN is defined.
package daq_link_pkg;

    localparam logic [7:0]  K_COMMA   = 8'hBC;
    localparam logic [7:0]  K_SOE     = 8'hFB;
    localparam logic [7:0]  K_EOE     = 8'hFD;
    localparam logic [31:0] IDLE_WORD = 32'h505050BC;
    localparam logic [3:0]  IDLE_IS_K = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_DATA = 3'd3,
`ifdef DAQ_LINK_FRAMER_CHECKSUM_EN
        ST_CSUM = 3'd4,
`endif
        ST_EOE  = 3'd5
    } state_e;

    function automatic logic [31:0] soe_word(input logic [7:0] id);
        return {16'h0000, id, K_SOE};
    endfunction

    function automatic logic [31:0] eoe_word(input logic [15:0] nwords);
        return {nwords, 8'h00, K_EOE};
    endfunction

endpackage

// File: rtl/daq_link_gap_ctr.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module daq_link_gap_ctr #(
    parameter int WIDTH   = 4,
    parameter int SAT_VAL = 15,
    parameter int RST_VAL = 15
) (
    input  logic             clk_link,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] SAT_V = WIDTH'(SAT_VAL);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_count;

    // Count up to the saturation value, clearing on request.
    always_ff @(posedge clk_link or posedge reset) begin
        if (reset) begin
            r_count <= RST_V;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != SAT_V)) begin
            r_count <= r_count + WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/daq_link_framer.sv
// DAQ link transmitter: frames payload events as SOE/HDR/data/[CSUM]/EOE on a
// 32-bit K-coded link, filling idle time with comma words.
// Optional checksum word: define DAQ_LINK_FRAMER_CHECKSUM_EN.
module daq_link_framer
    import daq_link_pkg::*;
#(
    parameter int IDLE_GAP     = 2,
    parameter int COMMA_PERIOD = 256
) (
    input  logic        clk_link,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  fpga_id,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] link_data,
    output logic [3:0]  link_is_k,
    output logic        link_valid,
    output logic [15:0] event_count,
    output logic        busy
);

    localparam logic [3:0]  GAP_MIN   = 4'(IDLE_GAP);
    localparam logic [15:0] COMMA_MAX = 16'(COMMA_PERIOD);
    localparam logic        COMMA_ON  = (COMMA_PERIOD != 0);

    state_e      r_state;
    logic [31:0] r_link_data;
    logic [3:0]  r_link_is_k;
    logic        r_link_valid;
    logic        r_busy;
    logic [15:0] r_event_count;
    logic [7:0]  r_fpga_id;
    logic [15:0] r_nwords;
`ifdef DAQ_LINK_FRAMER_CHECKSUM_EN
    logic [31:0] r_sum;
`endif

    logic [3:0]  w_gap_cnt;
    logic [15:0] w_comma_cnt;
    logic        w_comma_due;
    logic        w_s_ready;
    logic        w_accept;
    logic        w_start;

    // Inter-event gap: grows while idling, cleared by EOE; starts saturated.
    daq_link_gap_ctr #(.WIDTH(4), .SAT_VAL(15), .RST_VAL(15)) u_gap_ctr (
        .clk_link (clk_link),
        .reset    (reset),
        .i_inc    (r_state == ST_IDLE),
        .i_clr    (r_state == ST_EOE),
        .o_count  (w_gap_cnt)
    );

    // Comma spacing: consecutive accepted words; stall idles leave it alone.
    daq_link_gap_ctr #(.WIDTH(16), .SAT_VAL(65535), .RST_VAL(0)) u_comma_ctr (
        .clk_link (clk_link),
        .reset    (reset),
        .i_inc    (w_accept),
        .i_clr    ((r_state != ST_DATA) || w_comma_due),
        .o_count  (w_comma_cnt)
    );

    // Ready depends only on registered state and counters.
    assign w_comma_due = COMMA_ON && (w_comma_cnt == COMMA_MAX);
    assign w_s_ready   = (r_state == ST_DATA) && !w_comma_due;
    assign w_accept    = s_valid && w_s_ready;
    assign w_start     = enable && s_valid && (w_gap_cnt >= GAP_MIN);

    // Framing FSM with registered link outputs.
    always_ff @(posedge clk_link or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_link_data   <= IDLE_WORD;
            r_link_is_k   <= IDLE_IS_K;
            r_link_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_event_count <= 16'h0000;
            r_fpga_id     <= 8'h00;
            r_nwords      <= 16'h0000;
`ifdef DAQ_LINK_FRAMER_CHECKSUM_EN
            r_sum         <= 32'h0000_0000;
`endif
        end else begin
            r_link_valid <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_link_data <= IDLE_WORD;
                    r_link_is_k <= IDLE_IS_K;
                    r_busy      <= 1'b0;
                    r_fpga_id   <= fpga_id;
                    r_nwords    <= 16'h0000;
`ifdef DAQ_LINK_FRAMER_CHECKSUM_EN
                    r_sum       <= 32'h0000_0000;
`endif
                    if (w_start) begin
                        r_state <= ST_SOE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SOE: begin
                    r_link_data <= soe_word(r_fpga_id);
                    r_link_is_k <= 4'b0001;
                    r_busy      <= 1'b1;
                    r_state     <= ST_HDR;
                end
                ST_HDR: begin
                    r_link_data <= {16'h0000, r_event_count};
                    r_link_is_k <= 4'b0000;
                    r_busy      <= 1'b1;
                    r_state     <= ST_DATA;
                end
                ST_DATA: begin
                    r_busy <= 1'b1;
                    if (w_accept) begin
                        r_link_data <= s_data;
                        r_link_is_k <= 4'b0000;
                        r_nwords    <= r_nwords + 16'd1;
`ifdef DAQ_LINK_FRAMER_CHECKSUM_EN
                        r_sum       <= r_sum + s_data;
`endif
                        if (s_last) begin
`ifdef DAQ_LINK_FRAMER_CHECKSUM_EN
                            r_state <= ST_CSUM;
`else
                            r_state <= ST_EOE;
`endif
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else begin
                        r_link_data <= IDLE_WORD;
                        r_link_is_k <= IDLE_IS_K;
                        r_state     <= ST_DATA;
                    end
                end
`ifdef DAQ_LINK_FRAMER_CHECKSUM_EN
                ST_CSUM: begin
                    r_link_data <= r_sum;
                    r_link_is_k <= 4'b0000;
                    r_busy      <= 1'b1;
                    r_state     <= ST_EOE;
                end
`endif
                ST_EOE: begin
                    r_link_data   <= eoe_word(r_nwords);
                    r_link_is_k   <= 4'b0001;
                    r_busy        <= 1'b1;
                    r_event_count <= r_event_count + 16'd1;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_link_data <= IDLE_WORD;
                    r_link_is_k <= IDLE_IS_K;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready     = w_s_ready;
    assign link_data   = r_link_data;
    assign link_is_k   = r_link_is_k;
    assign link_valid  = r_link_valid;
    assign event_count = r_event_count;
    assign busy        = r_busy;

endmodule

// File: tb/tb_daq_link_framer.sv
// Scoreboard bench for daq_link_framer: the driver pushes expected framed
// words, monitors pop and compare non-idle link words.
module tb_daq_link_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  fpga_id = 8'h00;
    logic [31:0] s_data = 32'h0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] link_data;
    logic [3:0]  link_is_k;
    logic        link_valid;
    logic [15:0] event_count;
    logic        busy;

    logic        reset2 = 1'b0;
    logic [31:0] s_data2 = 32'h0;
    logic        s_valid2 = 1'b0;
    logic        s_last2 = 1'b0;
    logic        s_ready2;
    logic [31:0] link_data2;
    logic [3:0]  link_is_k2;
    logic        link_valid2;
    logic [15:0] event_count2;
    logic        busy2;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_evc = 0;
    int   idle_run = 0;
    int   seen_eoe = 0;
    int   soe_seen = 0;
    int   idle_busy = 0;
    int   stall_len[16];
    bit   done2 = 1'b0;

    always #5 clk = ~clk;

    daq_link_framer #(.IDLE_GAP(2), .COMMA_PERIOD(4)) dut (
        .clk_link(clk), .reset(reset), .enable(enable), .fpga_id(fpga_id),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .link_data(link_data), .link_is_k(link_is_k), .link_valid(link_valid),
        .event_count(event_count), .busy(busy)
    );

    daq_link_framer #(.IDLE_GAP(2), .COMMA_PERIOD(0)) dut_wrap (
        .clk_link(clk), .reset(reset2), .enable(1'b1), .fpga_id(8'h55),
        .s_data(s_data2), .s_valid(s_valid2), .s_last(s_last2), .s_ready(s_ready2),
        .link_data(link_data2), .link_is_k(link_is_k2), .link_valid(link_valid2),
        .event_count(event_count2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    function automatic void push(input logic [31:0] d, input logic [3:0] k);
        q.push_back({d, k});
    endfunction

    // Main monitor: idles counted, every other word checked against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (link_valid === 1'b1) begin
                if (link_data == 32'h505050BC && link_is_k == 4'b0001) begin
                    idle_run++;
                    if (busy) idle_busy++;
                end else begin
                    if (q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_word: got %h k %b, expected nothing", link_data, link_is_k);
                    end else begin
                        e = q.pop_front();
                        chk("link_word", {link_data, link_is_k}, {e.d, e.k});
                        chk("busy_in_event", {35'h0, busy}, 36'h1);
                    end
                    if (link_is_k == 4'b0001 && link_data[7:0] == 8'hFB) begin
                        soe_seen++;
                        if (seen_eoe != 0) chk("idle_gap_ge2", {35'h0, idle_run >= 2}, 36'h1);
                    end
                    if (link_is_k == 4'b0001 && link_data[7:0] == 8'hFD) seen_eoe = 1;
                    idle_run = 0;
                end
            end
        end
    end

    task automatic drain(input string name);
        int g;
        g = 0;
        while (q.size() != 0 && g < 300) begin
            @(negedge clk); #1;
            g++;
        end
        if (q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: got %0d words pending, expected 0", name, q.size());
            q.delete();
        end
        chk({name, "_event_count"}, {20'h0, event_count}, 36'(exp_evc));
    endtask

    task automatic send_event(input logic [7:0] id, input int n, input logic [31:0] base,
                              input bit toggle, input bit do_drain);
        logic [31:0] sum;
        int k, guard;
        bit acc;
        fpga_id = id;
        enable  = 1'b1;
        push({16'h0, id, 8'hFB}, 4'b0001);
        push({16'h0, 16'(exp_evc)}, 4'b0000);
        k = 0; guard = 0; sum = 32'h0;
        s_data = base + 32'd1; s_last = (n == 1); s_valid = 1'b1;
        while (k < n && guard < 1000) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            if (!toggle && k > 0 && s_valid && !s_ready && k <= 16) stall_len[k-1]++;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                push(s_data, 4'b0000);
                sum = sum + s_data;
                k++;
                s_data = base + 32'(k) + 32'd1;
                s_last = (k == n - 1);
            end
            if (k >= n) s_valid = 1'b0;
            else if (toggle) s_valid = !s_valid;
            else s_valid = 1'b1;
        end
        if (k < n) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: got %0d words accepted, expected %0d", k, n);
        end
        s_valid = 1'b0; s_last = 1'b0;
`ifdef DAQ_LINK_FRAMER_CHECKSUM_EN
        push(sum, 4'b0000);
`endif
        push({16'(n), 8'h00, 8'hFD}, 4'b0001);
        exp_evc++;
        if (do_drain) drain("event");
    endtask

    // Main directed sequence.
    initial begin
        int k, g, ib, soe0;
        bit acc;
        #1 reset = 1'b1;
        #12;
        chk("rst_link_data", {4'h0, link_data}, {4'h0, 32'h505050BC});
        chk("rst_link_is_k", {32'h0, link_is_k}, {32'h0, 4'b0001});
        chk("rst_link_valid", {35'h0, link_valid}, 36'h0);
        chk("rst_s_ready", {35'h0, s_ready}, 36'h0);
        chk("rst_busy", {35'h0, busy}, 36'h0);
        chk("rst_event_count", {20'h0, event_count}, 36'h0);
        @(negedge clk); reset = 1'b0; #1;
        chk("valid_before_edge", {35'h0, link_valid}, 36'h0);
        @(posedge clk); #1;
        chk("valid_after_edge", {35'h0, link_valid}, 36'h1);

        // Single event, then back-to-back pair, then stalled event.
        send_event(8'h2A, 3, 32'h0, 1'b0, 1'b1);
        send_event(8'h11, 2, 32'h100, 1'b0, 1'b0);
        send_event(8'h12, 3, 32'h200, 1'b0, 1'b1);
        ib = idle_busy;
        send_event(8'h13, 4, 32'h300, 1'b1, 1'b1);
        chk("stall_idles_interleaved", {35'h0, (idle_busy - ib) >= 3}, 36'h1);

        // Comma insertion every 4 words across a 10-word event.
        for (int i = 0; i < 16; i++) stall_len[i] = 0;
        send_event(8'h14, 10, 32'h400, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            chk($sformatf("comma_stall_after_word%0d", i + 1), 36'(stall_len[i]),
                (i == 3 || i == 7) ? 36'h1 : 36'h0);

        // Reset in the middle of an event.
        fpga_id = 8'h77;
        push({16'h0, 8'h77, 8'hFB}, 4'b0001);
        push({16'h0, 16'(exp_evc)}, 4'b0000);
        k = 0; g = 0;
        s_data = 32'h501; s_last = 1'b0; s_valid = 1'b1;
        while (k < 2 && g < 100) begin
            @(negedge clk); acc = s_valid && s_ready;
            @(posedge clk); #1; g++;
            if (acc) begin
                push(s_data, 4'b0000);
                k++;
                s_data = 32'h501 + 32'(k);
            end
        end
        @(negedge clk); #2;
        reset = 1'b1; #1;
        chk("abort_link_data", {4'h0, link_data}, {4'h0, 32'h505050BC});
        chk("abort_link_is_k", {32'h0, link_is_k}, {32'h0, 4'b0001});
        chk("abort_link_valid", {35'h0, link_valid}, 36'h0);
        chk("abort_s_ready", {35'h0, s_ready}, 36'h0);
        chk("abort_busy", {35'h0, busy}, 36'h0);
        chk("abort_event_count", {20'h0, event_count}, 36'h0);
        chk("abort_words_seen", 36'(q.size()), 36'h0);
        q.delete();
        exp_evc = 0;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        chk("rel_valid_before_edge", {35'h0, link_valid}, 36'h0);
        @(posedge clk); #1;
        chk("rel_valid_after_edge", {35'h0, link_valid}, 36'h1);

        // Enable low: requests pending but no event may start.
        enable = 1'b0; s_valid = 1'b1; s_data = 32'hDEAD0001;
        soe0 = soe_seen;
        repeat (30) @(posedge clk);
        @(negedge clk); #1;
        chk("disabled_no_soe", 36'(soe_seen), 36'(soe0));
        chk("disabled_s_ready", {35'h0, s_ready}, 36'h0);
        chk("disabled_busy", {35'h0, busy}, 36'h0);
        send_event(8'h3C, 2, 32'h600, 1'b0, 1'b1);

        // Wait for the long wrap event on the second instance.
        g = 0;
        while (!done2 && g < 70000) begin
            @(negedge clk); g++;
        end
        if (!done2) begin
            n_vec++; n_err++;
            $display("FAIL wrap_timeout: got no EOE, expected EOE within bound");
        end
        chk("final_queue_empty", 36'(q.size()), 36'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Driver for the 65537-word length-wrap event.
    initial begin
        int cnt, guard;
        bit acc;
        #1 reset2 = 1'b1;
        #20 reset2 = 1'b0;
        cnt = 0; guard = 0;
        s_data2 = 32'd1; s_last2 = 1'b0; s_valid2 = 1'b1;
        while (cnt < 65537 && guard < 80000) begin
            @(negedge clk); acc = s_valid2 && s_ready2;
            @(posedge clk); #1; guard++;
            if (acc) begin
                cnt++;
                s_data2 = 32'(cnt) + 32'd1;
                s_last2 = (cnt == 65536);
                if (cnt == 65537) s_valid2 = 1'b0;
            end
        end
        s_valid2 = 1'b0; s_last2 = 1'b0;
    end

    // Monitor for the wrap event: SOE, HDR, ordered data, [checksum], EOE.
    initial begin
        int p2, bad2;
        p2 = 0; bad2 = 0;
        forever begin
            @(negedge clk);
            if (link_valid2 === 1'b1 && !(link_data2 == 32'h505050BC && link_is_k2 == 4'b0001) && !done2) begin
                if (p2 == 0) chk("wrap_soe", {link_data2, link_is_k2}, {32'h000055FB, 4'b0001});
                else if (p2 == 1) chk("wrap_hdr", {link_data2, link_is_k2}, {32'h0, 4'b0000});
                else if (p2 <= 65538) begin
                    if ({link_data2, link_is_k2} !== {32'(p2 - 1), 4'b0000}) bad2++;
                end
`ifdef DAQ_LINK_FRAMER_CHECKSUM_EN
                else if (p2 == 65539) chk("wrap_csum", {link_data2, link_is_k2}, {32'h80018001, 4'b0000});
                else begin
`else
                else begin
`endif
                    chk("wrap_data_errors", 36'(bad2), 36'h0);
                    chk("wrap_eoe", {link_data2, link_is_k2}, {32'h000100FD, 4'b0001});
                    done2 = 1'b1;
                end
                p2++;
            end
        end
    end

endmodule
